// File: rtl/tlk2711_pkg.sv
//==============================================================================
// Module      : tlk2711_pkg
// Description : Shared TLK2711 link constants, receive FSM state type and
//               received-word classification used by the link datapath.
// Contents    : K28_5/D5_6/D11_5 code bytes, rx_state_t, word_class_t,
//               classify() helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package tlk2711_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D11_5 = 8'hAB;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ALIGN = 2'd1,
        DATA  = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        COMMA = 2'd0,
        SOFW  = 2'd1,
        DATAW = 2'd2,
        BAD   = 2'd3
    } word_class_t;

    // Only the MSB byte may carry a K-code; a K-flag on the LSB byte, or a
    // K-flagged word other than comma/SOF, is a line error.
    function automatic word_class_t classify(input logic [15:0] word,
                                             input logic        kmsb,
                                             input logic        klsb);
        word_class_t cls;
        cls = BAD;
        if (!kmsb && !klsb)
            cls = DATAW;
        else if (kmsb && !klsb && word == {K28_5, D5_6})
            cls = COMMA;
        else if (kmsb && !klsb && word == {K28_5, D11_5})
            cls = SOFW;
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlk2711_sat_cnt.sv
//==============================================================================
// Module      : tlk2711_sat_cnt
// Description : Saturating up-counter with synchronous clear. Clear wins over
//               a same-cycle increment.
// Ports       : clk, rst_n (sync, active-low), inc, clr, count[CNT_W-1:0]
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tlk2711_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            count <= '0;
        else if (inc && count != {CNT_W{1'b1}})
            count <= count + CNT_W'(1);
    end

endmodule

`default_nettype wire

// File: rtl/tlk2711_rx_checker.sv
//==============================================================================
// Module      : tlk2711_rx_checker
// Description : TLK2711 receive deframer/checker. Hunts comma alignment and
//               SOF, emits payload words with sof/eof markers, checks payload
//               against the counting pattern {idx,idx} and keeps saturating
//               frame/error statistics. Input-to-o_data_vld latency is 2.
// Ports       : clk, rst_n (sync, active-low)
//               i_rxd[15:0], i_rkmsb, i_rklsb  - TLK2711 receive bus
//               i_clr                          - clear counters and capture
//               o_data[15:0], o_data_vld, o_sof, o_eof - payload stream
//               o_sync                          - link aligned
//               o_frame_cnt, o_err_cnt [CNT_W]  - saturating statistics
//               o_err_word[15:0], o_err_idx[7:0] - first payload error
// Config      : `define TLK_RX_ERR_CAPTURE_EN builds the first-error capture
//               registers; otherwise o_err_word/o_err_idx are tied to 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tlk2711_rx_checker
    import tlk2711_pkg::*;
#(
    parameter int FRAME_LEN = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      i_rxd,
    input  logic             i_rkmsb,
    input  logic             i_rklsb,
    input  logic             i_clr,
    output logic [15:0]      o_data,
    output logic             o_data_vld,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_sync,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [15:0]      o_err_word,
    output logic [7:0]       o_err_idx
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    logic [15:0] rxd_q;
    logic        rkmsb_q;
    logic        rklsb_q;
    word_class_t cls;

    rx_state_t   state;
    rx_state_t   state_nx;
    logic [7:0]  idx;
    logic [7:0]  idx_nx;
    logic        frame_bad;
    logic        frame_bad_nx;
    logic        sync_nx;
    logic [15:0] data_nx;
    logic        vld_nx;
    logic        sof_nx;
    logic        eof_nx;
    logic        err_inc;
    logic        frm_inc;
    logic        mismatch;

    assign cls = classify(rxd_q, rkmsb_q, rklsb_q);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= HUNT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        frame_bad_nx = frame_bad;
        sync_nx      = o_sync;
        data_nx      = o_data;
        vld_nx       = 1'b0;
        sof_nx       = 1'b0;
        eof_nx       = 1'b0;
        err_inc      = 1'b0;
        frm_inc      = 1'b0;
        mismatch     = 1'b0;
        unique case (state)
            HUNT: begin
                if (cls == COMMA)
                    state_nx = ALIGN;
            end
            ALIGN: begin
                case (cls)
                    COMMA: ;
                    SOFW: begin
                        state_nx     = DATA;
                        idx_nx       = 8'd0;
                        frame_bad_nx = 1'b0;
                        sync_nx      = 1'b1;
                    end
                    default: begin
                        // Losing alignment only counts as a fault if we had it.
                        state_nx = HUNT;
                        sync_nx  = 1'b0;
                        err_inc  = o_sync;
                    end
                endcase
            end
            DATA: begin
                if (cls == DATAW) begin
                    mismatch     = (rxd_q != {idx, idx});
                    vld_nx       = 1'b1;
                    data_nx      = rxd_q;
                    sof_nx       = (idx == 8'd0);
                    eof_nx       = (idx == LAST_IDX);
                    err_inc      = mismatch;
                    frame_bad_nx = frame_bad | mismatch;
                    if (idx == LAST_IDX) begin
                        state_nx = ALIGN;
                        frm_inc  = ~(frame_bad | mismatch);
                    end else begin
                        idx_nx = idx + 8'd1;
                    end
                end else begin
                    // Truncated frame: a comma keeps us word-aligned, anything
                    // else sends us back to hunting.
                    err_inc  = 1'b1;
                    sync_nx  = 1'b0;
                    state_nx = (cls == COMMA) ? ALIGN : HUNT;
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_q      <= '0;
            rkmsb_q    <= 1'b0;
            rklsb_q    <= 1'b0;
            idx        <= '0;
            frame_bad  <= 1'b0;
            o_sync     <= 1'b0;
            o_data     <= '0;
            o_data_vld <= 1'b0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
        end else begin
            rxd_q      <= i_rxd;
            rkmsb_q    <= i_rkmsb;
            rklsb_q    <= i_rklsb;
            idx        <= idx_nx;
            frame_bad  <= frame_bad_nx;
            o_sync     <= sync_nx;
            o_data     <= data_nx;
            o_data_vld <= vld_nx;
            o_sof      <= sof_nx;
            o_eof      <= eof_nx;
        end
    end

    tlk2711_sat_cnt #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frm_inc),
        .clr   (i_clr),
        .count (o_frame_cnt)
    );

    tlk2711_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (i_clr),
        .count (o_err_cnt)
    );

`ifdef TLK_RX_ERR_CAPTURE_EN
    logic captured;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            captured   <= 1'b0;
            o_err_word <= '0;
            o_err_idx  <= '0;
        end else if (mismatch && !captured) begin
            captured   <= 1'b1;
            o_err_word <= rxd_q;
            o_err_idx  <= idx;
        end
    end
`else
    assign o_err_word = '0;
    assign o_err_idx  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tlk2711_rx_checker.sv
//==============================================================================
// Module      : tb_tlk2711_rx_checker
// Description : Self-checking bench for tlk2711_rx_checker. A behavioural
//               model of the link rules predicts every output each cycle;
//               scenario tasks add absolute checks on the expected totals.
//               Counters are built 8 bits wide so saturation is reachable
//               in a few hundred cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tlk2711_rx_checker;

    localparam int FRAME_LEN = 32;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [15:0]      i_rxd = 16'h0;
    logic             i_rkmsb = 1'b0;
    logic             i_rklsb = 1'b0;
    logic             i_clr = 1'b0;
    logic [15:0]      o_data;
    logic             o_data_vld;
    logic             o_sof;
    logic             o_eof;
    logic             o_sync;
    logic [CNT_W-1:0] o_frame_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic [15:0]      o_err_word;
    logic [7:0]       o_err_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlk2711_rx_checker #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rxd       (i_rxd),
        .i_rkmsb     (i_rkmsb),
        .i_rklsb     (i_rklsb),
        .i_clr       (i_clr),
        .o_data      (o_data),
        .o_data_vld  (o_data_vld),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .o_sync      (o_sync),
        .o_frame_cnt (o_frame_cnt),
        .o_err_cnt   (o_err_cnt),
        .o_err_word  (o_err_word),
        .o_err_idx   (o_err_idx)
    );

    // ---------------- reference model ----------------
    // mode: 0 hunting, 1 aligned waiting for SOF, 2 inside a frame
    int          m_mode, m_idx, m_frames, m_errs, m_cap_i;
    bit          m_bad, m_sync, m_cap_done;
    logic [15:0] m_cap_w;
    bit          e_vld, e_sof, e_eof;
    logic [15:0] e_data;
    logic [15:0] h_w;
    bit          h_km, h_kl;

    always @(posedge clk) begin : model
        bit is_comma, is_sof, is_data, add_err, add_frm;
        if (!rst_n) begin
            m_mode = 0; m_idx = 0; m_frames = 0; m_errs = 0; m_cap_i = 0;
            m_bad = 0; m_sync = 0; m_cap_done = 0; m_cap_w = 16'h0;
            e_vld = 0; e_sof = 0; e_eof = 0;
            h_w = 16'h0; h_km = 0; h_kl = 0;
        end else begin
            is_comma = h_km && !h_kl && h_w == 16'hBCC5;
            is_sof   = h_km && !h_kl && h_w == 16'hBCAB;
            is_data  = !h_km && !h_kl;
            add_err = 0; add_frm = 0;
            e_vld = 0; e_sof = 0; e_eof = 0;
            if (m_mode == 0) begin
                if (is_comma) m_mode = 1;
            end else if (m_mode == 1) begin
                if (is_sof) begin
                    m_mode = 2; m_idx = 0; m_bad = 0; m_sync = 1;
                end else if (!is_comma) begin
                    add_err = m_sync; m_sync = 0; m_mode = 0;
                end
            end else begin
                if (is_data) begin
                    e_vld = 1; e_data = h_w;
                    e_sof = (m_idx == 0);
                    e_eof = (m_idx == FRAME_LEN - 1);
                    if (h_w != 16'(m_idx * 257)) begin
                        add_err = 1; m_bad = 1;
                        if (!m_cap_done) begin
                            m_cap_done = 1; m_cap_w = h_w; m_cap_i = m_idx;
                        end
                    end
                    if (m_idx == FRAME_LEN - 1) begin
                        add_frm = !m_bad; m_mode = 1;
                    end else begin
                        m_idx++;
                    end
                end else begin
                    add_err = 1; m_sync = 0;
                    m_mode = is_comma ? 1 : 0;
                end
            end
            if (add_err && m_errs < CNT_MAX) m_errs++;
            if (add_frm && m_frames < CNT_MAX) m_frames++;
            if (i_clr) begin
                m_errs = 0; m_frames = 0; m_cap_done = 0; m_cap_w = 16'h0; m_cap_i = 0;
            end
            h_w = i_rxd; h_km = i_rkmsb; h_kl = i_rklsb;
        end
    end

    // ---------------- per-cycle comparison ----------------
    int          n_vld, n_sof, n_eof;
    logic [15:0] sof_data, eof_data;

    always @(posedge clk) begin : monitor
        logic [15:0] exp_ew;
        logic [7:0]  exp_ei;
        #1;
`ifdef TLK_RX_ERR_CAPTURE_EN
        exp_ew = m_cap_w; exp_ei = 8'(m_cap_i);
`else
        exp_ew = 16'h0; exp_ei = 8'h0;
`endif
        checks++;
        if (o_data_vld !== e_vld) begin
            errors++; $display("FAIL vld @%0t: got %b want %b", $time, o_data_vld, e_vld);
        end
        if (e_vld && o_data_vld === 1'b1) begin
            checks += 3;
            if (o_data !== e_data) begin
                errors++; $display("FAIL data @%0t: got %h want %h", $time, o_data, e_data);
            end
            if (o_sof !== e_sof) begin
                errors++; $display("FAIL sof @%0t: got %b want %b", $time, o_sof, e_sof);
            end
            if (o_eof !== e_eof) begin
                errors++; $display("FAIL eof @%0t: got %b want %b", $time, o_eof, e_eof);
            end
        end
        checks += 5;
        if (o_sync !== m_sync) begin
            errors++; $display("FAIL sync @%0t: got %b want %b", $time, o_sync, m_sync);
        end
        if (o_frame_cnt !== CNT_W'(m_frames)) begin
            errors++; $display("FAIL frame_cnt @%0t: got %0d want %0d", $time, o_frame_cnt, m_frames);
        end
        if (o_err_cnt !== CNT_W'(m_errs)) begin
            errors++; $display("FAIL err_cnt @%0t: got %0d want %0d", $time, o_err_cnt, m_errs);
        end
        if (o_err_word !== exp_ew) begin
            errors++; $display("FAIL err_word @%0t: got %h want %h", $time, o_err_word, exp_ew);
        end
        if (o_err_idx !== exp_ei) begin
            errors++; $display("FAIL err_idx @%0t: got %0d want %0d", $time, o_err_idx, exp_ei);
        end
        if (o_data_vld === 1'b1) begin
            n_vld++;
            if (o_sof === 1'b1) begin n_sof++; sof_data = o_data; end
            if (o_eof === 1'b1) begin n_eof++; eof_data = o_data; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input logic [15:0] w, input logic km, input logic kl, input logic clr);
        @(negedge clk);
        i_rxd = w; i_rkmsb = km; i_rklsb = kl; i_clr = clr;
    endtask

    task automatic put_comma(input int n);
        for (int i = 0; i < n; i++) put(16'hBCC5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic put_sof();
        put(16'hBCAB, 1'b1, 1'b0, 1'b0);
    endtask

    // Counting-pattern frame; optional single corrupted word, truncation by a
    // comma at cut_idx, or corruption of every word.
    task automatic send_frame(input int bad_idx, input logic [15:0] bad_val,
                              input int cut_idx, input bit all_bad);
        logic [15:0] w;
        for (int n = 0; n < FRAME_LEN; n++) begin
            if (n == cut_idx) begin
                put(16'hBCC5, 1'b1, 1'b0, 1'b0);
                return;
            end
            w = 16'(n * 257);
            if (all_bad) w = w ^ 16'($urandom_range(1, 65535));
            else if (n == bad_idx) w = bad_val;
            put(w, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; i_clr = 1'b0;
        i_rxd = 16'($urandom); i_rkmsb = 1'($urandom); i_rklsb = 1'($urandom);
        @(negedge clk);
        rst_n = 1'b1;
        i_rxd = 16'h0; i_rkmsb = 1'b0; i_rklsb = 1'b0;
        n_vld = 0; n_sof = 0; n_eof = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks += 7;
        if (o_data_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", o_data_vld); end
        if (o_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", o_sof); end
        if (o_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b want 0", o_eof); end
        if (o_sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b want 0", o_sync); end
        if (o_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data); end
        if (o_frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", o_frame_cnt); end
        if (o_err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", o_err_cnt); end
    endtask

    task automatic test_clean_frames();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            put_comma(2); put_sof(); send_frame(-1, 16'h0, -1, 1'b0);
        end
        put_comma(3);
        checks += 8;
        if (o_sync !== 1'b1) begin errors++; $display("FAIL clean_sync: got %b want 1", o_sync); end
        if (o_frame_cnt !== 8'd3) begin errors++; $display("FAIL clean_frame_cnt: got %0d want 3", o_frame_cnt); end
        if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL clean_err_cnt: got %0d want 0", o_err_cnt); end
        if (n_vld != 96) begin errors++; $display("FAIL clean_vld_count: got %0d want 96", n_vld); end
        if (n_sof != 3) begin errors++; $display("FAIL clean_sof_count: got %0d want 3", n_sof); end
        if (n_eof != 3) begin errors++; $display("FAIL clean_eof_count: got %0d want 3", n_eof); end
        if (sof_data !== 16'h0000) begin errors++; $display("FAIL clean_sof_word: got %h want 0000", sof_data); end
        if (eof_data !== 16'h1F1F) begin errors++; $display("FAIL clean_eof_word: got %h want 1f1f", eof_data); end
    endtask

    task automatic test_payload_error();
        int          r1, r2;
        logic [15:0] v1, v2;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            put_comma(2); put_sof(); send_frame(f == 1 ? 5 : -1, 16'h0506, -1, 1'b0);
        end
        put_comma(3);
        checks += 3;
        if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL perr_err_cnt: got %0d want 1", o_err_cnt); end
        if (o_frame_cnt !== 8'd2) begin errors++; $display("FAIL perr_frame_cnt: got %0d want 2", o_frame_cnt); end
        if (o_sync !== 1'b1) begin errors++; $display("FAIL perr_sync: got %b want 1", o_sync); end
`ifdef TLK_RX_ERR_CAPTURE_EN
        checks += 2;
        if (o_err_word !== 16'h0506) begin errors++; $display("FAIL perr_word: got %h want 0506", o_err_word); end
        if (o_err_idx !== 8'd5) begin errors++; $display("FAIL perr_idx: got %0d want 5", o_err_idx); end
`endif
        // random corruption after a clear; the first one must stick
        r1 = $urandom_range(0, FRAME_LEN - 1);
        r2 = $urandom_range(0, FRAME_LEN - 1);
        v1 = 16'(r1 * 257) ^ 16'($urandom_range(1, 65535));
        v2 = 16'(r2 * 257) ^ 16'($urandom_range(1, 65535));
        put(16'hBCC5, 1'b1, 1'b0, 1'b1);
        put_comma(1); put_sof(); send_frame(r1, v1, -1, 1'b0);
        put_comma(1); put_sof(); send_frame(r2, v2, -1, 1'b0);
        put_comma(3);
        checks += 2;
        if (o_err_cnt !== 8'd2) begin errors++; $display("FAIL perr2_err_cnt: got %0d want 2", o_err_cnt); end
        if (o_frame_cnt !== 8'd0) begin errors++; $display("FAIL perr2_frame_cnt: got %0d want 0", o_frame_cnt); end
`ifdef TLK_RX_ERR_CAPTURE_EN
        checks += 2;
        if (o_err_word !== v1) begin errors++; $display("FAIL perr2_word: got %h want %h", o_err_word, v1); end
        if (o_err_idx !== 8'(r1)) begin errors++; $display("FAIL perr2_idx: got %0d want %0d", o_err_idx, r1); end
`endif
    endtask

    task automatic test_truncated();
        do_reset();
        put_comma(2); put_sof(); send_frame(-1, 16'h0, 10, 1'b0);
        put_comma(3);
        checks += 4;
        if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL trunc_err_cnt: got %0d want 1", o_err_cnt); end
        if (o_sync !== 1'b0) begin errors++; $display("FAIL trunc_sync: got %b want 0", o_sync); end
        if (n_eof != 0) begin errors++; $display("FAIL trunc_eof_count: got %0d want 0", n_eof); end
        if (n_vld != 10) begin errors++; $display("FAIL trunc_vld_count: got %0d want 10", n_vld); end
        // SOF straight away: only accepted if the FSM sits in ALIGN
        put_sof(); send_frame(-1, 16'h0, -1, 1'b0);
        put_comma(3);
        checks += 3;
        if (o_sync !== 1'b1) begin errors++; $display("FAIL reacq_sync: got %b want 1", o_sync); end
        if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL reacq_frame_cnt: got %0d want 1", o_frame_cnt); end
        if (n_eof != 1) begin errors++; $display("FAIL reacq_eof_count: got %0d want 1", n_eof); end
    endtask

    task automatic test_comma_only();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 0) put(16'($urandom), 1'b0, 1'b0, 1'b0);
            else                           put(16'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        put_comma(1000);
        put_comma(2);
        checks += 4;
        if (n_vld != 0) begin errors++; $display("FAIL comma_vld_count: got %0d want 0", n_vld); end
        if (o_sync !== 1'b0) begin errors++; $display("FAIL comma_sync: got %b want 0", o_sync); end
        if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL comma_err_cnt: got %0d want 0", o_err_cnt); end
        if (o_frame_cnt !== 8'd0) begin errors++; $display("FAIL comma_frame_cnt: got %0d want 0", o_frame_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int f = 0; f < 9; f++) begin
            put_comma(1); put_sof(); send_frame(-1, 16'h0, -1, 1'b1);
        end
        put_comma(2);
        checks += 1;
        if (o_err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_err_cnt: got %h want ff", o_err_cnt); end
        put_sof(); send_frame($urandom_range(0, FRAME_LEN - 1), 16'hFFFF, -1, 1'b0);
        put_sof(); send_frame(-1, 16'h0, -1, 1'b0);
        put_comma(2);
        checks += 2;
        if (o_err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold_err_cnt: got %h want ff", o_err_cnt); end
        if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL sat_frame_cnt: got %0d want 1", o_frame_cnt); end
        // clear lands in the same cycle as the next frame completion
        put_sof(); send_frame(-1, 16'h0, -1, 1'b0);
        put(16'hBCC5, 1'b1, 1'b0, 1'b1);
        put_comma(2);
        checks += 2;
        if (o_frame_cnt !== 8'd0) begin errors++; $display("FAIL clr_frame_cnt: got %0d want 0", o_frame_cnt); end
        if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt: got %0d want 0", o_err_cnt); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        put_comma(2); put_sof();
        for (int n = 0; n < 20; n++) put(16'(n * 257), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; i_rxd = 16'(20 * 257);
        @(negedge clk);
        checks += 5;
        if (o_data_vld !== 1'b0) begin errors++; $display("FAIL mrst_vld: got %b want 0", o_data_vld); end
        if (o_sync !== 1'b0) begin errors++; $display("FAIL mrst_sync: got %b want 0", o_sync); end
        if (o_data !== 16'h0) begin errors++; $display("FAIL mrst_data: got %h want 0", o_data); end
        if (o_sof !== 1'b0 || o_eof !== 1'b0) begin errors++; $display("FAIL mrst_markers: got %b%b want 00", o_sof, o_eof); end
        if (o_frame_cnt !== '0) begin errors++; $display("FAIL mrst_frame_cnt: got %0d want 0", o_frame_cnt); end
        rst_n = 1'b1;
        put_comma(1); put_sof(); send_frame(-1, 16'h0, -1, 1'b0);
        put_comma(2);
        checks += 2;
        if (o_frame_cnt !== 8'd1) begin errors++; $display("FAIL mrst_after_frame_cnt: got %0d want 1", o_frame_cnt); end
        if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL mrst_after_err_cnt: got %0d want 0", o_err_cnt); end
    endtask

    task automatic test_random();
        int sel;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                put_comma($urandom_range(0, 3)); put_sof();
                send_frame(($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, FRAME_LEN - 1),
                           16'($urandom),
                           ($urandom_range(0, 4) == 0) ? $urandom_range(0, FRAME_LEN - 1) : -1,
                           1'b0);
            end else if (sel == 6) begin
                put(16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end else if (sel == 7) begin
                put(16'hBCC5, 1'b1, 1'b0, 1'b1);
            end else if (sel == 8) begin
                put_sof();
            end else begin
                put(16'($urandom), 1'b0, 1'b0, 1'b0);
            end
        end
        put_comma(3);
        checks += 2;
        if (o_frame_cnt !== CNT_W'(m_frames)) begin errors++; $display("FAIL rand_frame_cnt: got %0d want %0d", o_frame_cnt, m_frames); end
        if (o_err_cnt !== CNT_W'(m_errs)) begin errors++; $display("FAIL rand_err_cnt: got %0d want %0d", o_err_cnt, m_errs); end
    endtask

    initial begin
        test_reset();
        test_clean_frames();
        test_payload_error();
        test_truncated();
        test_comma_only();
        test_saturation();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
